// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle for bcd_updown_counter. The master drives the controls and the slave returns the count.
// dbg_state mirrors the run/pause FSM register so checkers can bind to it.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 2
);
   logic                  ctrl;
   logic                  dir;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  running;
   logic                  wrap;
   logic                  dbg_state;

   modport master (
      output ctrl, dir, load, load_val,
      input  count, running, wrap, dbg_state
   );

   modport slave (
      input  ctrl, dir, load, load_val,
      output count, running, wrap, dbg_state
   );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with an edge-toggled run/pause FSM, parallel load and a terminal pulse.
// Optional macro BCD_CNT_SAT_EN: saturate at the terminal value and drop to PAUSE instead of wrapping.
module bcd_updown_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   bcd_updown_counter_if.slave   bus
);

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic                  ctrl_q, ctrl_d;
   logic [4*DIGITS-1:0]   count_q, count_d;
   logic                  wrap_q, wrap_d;

   logic                  ctrl_rise;
   logic [4*DIGITS-1:0]   step_cnt;
   logic [4*DIGITS-1:0]   load_clamped;
   logic                  terminal;
   logic [3:0]            digit;

   always_comb begin
      ctrl_d    = bus.ctrl;
      ctrl_rise = bus.ctrl & ~ctrl_q;
      state_d   = state_q;
      if (ctrl_rise) begin
         state_d = (state_q == RUN) ? PAUSE : RUN;
      end

      // Ripple the carry/borrow through all decades; a carry out of the top means a terminal step.
      step_cnt     = count_q;
      load_clamped = '0;
      terminal     = 1'b1;
      digit        = '0;
      for (int i = 0; i < DIGITS; i++) begin
         digit = count_q[4*i +: 4];
         if (terminal) begin
            if (!bus.dir) begin
               if (digit == 4'd9) begin
                  step_cnt[4*i +: 4] = 4'd0;
               end else begin
                  step_cnt[4*i +: 4] = digit + 4'd1;
                  terminal           = 1'b0;
               end
            end else begin
               if (digit == 4'd0) begin
                  step_cnt[4*i +: 4] = 4'd9;
               end else begin
                  step_cnt[4*i +: 4] = digit - 4'd1;
                  terminal           = 1'b0;
               end
            end
         end
         load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
      end

      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = load_clamped;
      end else if (state_q == RUN) begin
         if (terminal) begin
            wrap_d = 1'b1;
`ifdef BCD_CNT_SAT_EN
            count_d = count_q;
            state_d = PAUSE;
`else
            count_d = step_cnt;
`endif
         end else begin
            count_d = step_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PAUSE;
         ctrl_q  <= 1'b0;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count     = count_q;
   assign bus.running   = (state_q == RUN);
   assign bus.wrap      = wrap_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 2-digit and a 4-digit instance checked against an integer-valued model.
// Honours BCD_CNT_SAT_EN in the model so the same bench serves both builds.
module tb_bcd_updown_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_updown_counter_if #(.DIGITS(2)) if2 ();
   bcd_updown_counter_if #(.DIGITS(4)) if4 ();

   bcd_updown_counter #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   bcd_updown_counter #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus per instance (0 = 2 digits, 1 = 4 digits)
   logic        s_ctrl [2];
   logic        s_dir  [2];
   logic        s_load [2];
   logic [31:0] s_lv   [2];

   // reference model: count held as a plain integer
   int m_digits [2] = '{2, 4};
   int m_val    [2];
   bit m_run    [2];
   bit m_cprev  [2];
   bit m_wrap   [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic int load_value(input logic [31:0] lv, input int digits);
      int v = 0;
      for (int i = 0; i < digits; i++) begin
         int nib = int'((lv >> (4*i)) & 32'hF);
         if (nib > 9) nib = 9;
         v += nib * pow10(i);
      end
      return v;
   endfunction

   function automatic logic [31:0] to_bcd(input int v, input int digits);
      logic [31:0] r = '0;
      for (int i = 0; i < digits; i++) begin
         r = r | (32'((v / pow10(i)) % 10) << (4*i));
      end
      return r;
   endfunction

   task automatic model_edge(input int k);
      int  top;
      bit  rise;
      bit  nrun;
      top = pow10(m_digits[k]) - 1;
      if (rst) begin
         m_val[k] = 0; m_run[k] = 0; m_cprev[k] = 0; m_wrap[k] = 0;
      end else begin
         rise        = s_ctrl[k] && !m_cprev[k];
         m_cprev[k]  = s_ctrl[k];
         m_wrap[k]   = 0;
         nrun        = m_run[k] ^ rise;
         if (s_load[k]) begin
            m_val[k] = load_value(s_lv[k], m_digits[k]);
         end else if (m_run[k]) begin
            if ((!s_dir[k] && m_val[k] == top) || (s_dir[k] && m_val[k] == 0)) begin
               m_wrap[k] = 1;
`ifdef BCD_CNT_SAT_EN
               nrun = 0;
`else
               m_val[k] = s_dir[k] ? top : 0;
`endif
            end else begin
               m_val[k] = s_dir[k] ? m_val[k] - 1 : m_val[k] + 1;
            end
         end
         m_run[k] = nrun;
      end
   endtask

   task automatic set_in(input int k, input logic c, input logic d, input logic l, input logic [31:0] lv);
      s_ctrl[k] = c; s_dir[k] = d; s_load[k] = l; s_lv[k] = lv;
   endtask

   // one clock: drive, let the edge happen, advance the model, compare at the falling edge
   task automatic tick(input logic rst_i);
      rst          = rst_i;
      if2.ctrl     = s_ctrl[0]; if2.dir = s_dir[0]; if2.load = s_load[0]; if2.load_val = s_lv[0][7:0];
      if4.ctrl     = s_ctrl[1]; if4.dir = s_dir[1]; if4.load = s_load[1]; if4.load_val = s_lv[1][15:0];
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_eq("count2",   32'(if2.count),   to_bcd(m_val[0], 2));
      check_eq("running2", 32'(if2.running), 32'(m_run[0]));
      check_eq("wrap2",    32'(if2.wrap),    32'(m_wrap[0]));
      check_eq("count4",   32'(if4.count),   to_bcd(m_val[1], 4));
      check_eq("running4", 32'(if4.running), 32'(m_run[1]));
      check_eq("wrap4",    32'(if4.wrap),    32'(m_wrap[1]));
   endtask

   task automatic idle_all();
      set_in(0, 1'b0, s_dir[0], 1'b0, '0);
      set_in(1, 1'b0, s_dir[1], 1'b0, '0);
   endtask

   // bring instance k into RUN using the model's own view of the FSM
   task automatic ensure_run(input int k);
      if (!m_run[k]) begin
         s_ctrl[k] = 1'b1;
         tick(1'b0);
         s_ctrl[k] = 1'b0;
      end
   endtask

   task automatic ensure_pause(input int k);
      if (m_run[k]) begin
         s_ctrl[k] = 1'b1;
         tick(1'b0);
         s_ctrl[k] = 1'b0;
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         set_in(k, 1'b0, 1'b0, 1'b0, '0);
         m_val[k] = 0; m_run[k] = 0; m_cprev[k] = 0; m_wrap[k] = 0;
      end

      // reset and idle
      tick(1'b1);
      tick(1'b1);
      check_eq("rst_count2", 32'(if2.count), 32'h00);
      check_eq("rst_running2", 32'(if2.running), 32'h0);
      check_eq("rst_wrap2", 32'(if2.wrap), 32'h0);
      for (int i = 0; i < 10; i++) tick(1'b0);
      check_eq("idle_count2", 32'(if2.count), 32'h00);

      // single ctrl pulse then counting up
      set_in(0, 1'b1, 1'b0, 1'b0, '0);
      tick(1'b0);
      check_eq("pulse_running2", 32'(if2.running), 32'h1);
      s_ctrl[0] = 1'b0;
      for (int i = 0; i < 12; i++) tick(1'b0);

      // ctrl held high toggles only once
      s_ctrl[0] = 1'b1;
      for (int i = 0; i < 5; i++) tick(1'b0);
      s_ctrl[0] = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0);

      // load 98 and run up through the terminal value
      set_in(0, 1'b0, 1'b0, 1'b1, 32'h98);
      tick(1'b0);
      check_eq("load98", 32'(if2.count), 32'h98);
      s_load[0] = 1'b0;
      ensure_run(0);
      for (int i = 0; i < 5; i++) tick(1'b0);

      // load 01, count down through 00
      ensure_pause(0);
      set_in(0, 1'b0, 1'b1, 1'b1, 32'h01);
      tick(1'b0);
      s_load[0] = 1'b0;
      ensure_run(0);
      for (int i = 0; i < 4; i++) tick(1'b0);
      s_dir[0] = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0);

      // clamped load, then load coincident with a ctrl rise while running
      set_in(0, 1'b0, 1'b0, 1'b1, 32'hA7);
      tick(1'b0);
      check_eq("clamp_a7", 32'(if2.count), 32'h97);
      s_load[0] = 1'b0;
      ensure_run(0);
      tick(1'b0);
      set_in(0, 1'b1, 1'b0, 1'b1, 32'h42);
      tick(1'b0);
      check_eq("load_ctrl_count", 32'(if2.count), 32'h42);
      check_eq("load_ctrl_run", 32'(if2.running), 32'h0);
      idle_all();
      tick(1'b0);

      // 4-digit ripple carry, then reset while running
      set_in(1, 1'b0, 1'b0, 1'b1, 32'h0999);
      tick(1'b0);
      s_load[1] = 1'b0;
      ensure_run(1);
      if (m_val[1] != 999) begin
         set_in(1, 1'b0, 1'b0, 1'b1, 32'h0999);
         tick(1'b0);
         s_load[1] = 1'b0;
      end
      tick(1'b0);
      check_eq("ripple4", 32'(if4.count), 32'h1000);
      tick(1'b1);
      check_eq("rst_run_count4", 32'(if4.count), 32'h0000);
      check_eq("rst_run_running4", 32'(if4.running), 32'h0);

      // randomized traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) begin
            s_ctrl[k] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) s_dir[k] = ~s_dir[k];
            s_load[k] = ($urandom_range(0, 15) == 0);
            s_lv[k]   = $urandom;
         end
         tick($urandom_range(0, 99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
